// File: rtl/regfile.sv
// regfile: 2**AW x DW register file with two combinational read ports and one write port; r0 reads as zero
// Ports: Clk clock; Clr async active-high clear; Rna/Rnb read register numbers -> Qa/Qb; Wn/D/We write port.
// Option: define REGFILE_BYPASS_EN to forward D to a read port that addresses the register being written.
module regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic [AW-1:0] Rna,
  input  logic [AW-1:0] Rnb,
  input  logic [AW-1:0] Wn,
  input  logic [DW-1:0] D,
  input  logic          We,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb
);
  logic [DW-1:0] r [2**AW];
  always_ff @(posedge Clk or posedge Clr)
    if (Clr) r <= '{default: '0};
    else if (We && Wn != '0) r[Wn] <= D;
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    Qa = Clr ? '0 : (We && Wn == Rna && Rna != '0) ? D : r[Rna];
    Qb = Clr ? '0 : (We && Wn == Rnb && Rnb != '0) ? D : r[Rnb];
  end
`else
  always_comb begin
    Qa = Clr ? '0 : r[Rna];
    Qb = Clr ? '0 : r[Rnb];
  end
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed table-driven bench for regfile
module tb_regfile;
  logic        Clk = 0, Clr = 1, We = 0;
  logic [4:0]  Rna = 0, Rnb = 0, Wn = 0;
  logic [31:0] D = 0, Qa, Qb;
  int checks = 0, errors = 0;

  regfile #(.DW(32), .AW(5)) dut (
    .Clk(Clk), .Clr(Clr), .Rna(Rna), .Rnb(Rnb), .Wn(Wn),
    .D(D), .We(We), .Qa(Qa), .Qb(Qb)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       nm;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    v[0] = '{"w_r1_666",     1'b1, 5'd1,  32'h666,      5'd1,  5'd31, 32'h666,      32'h0};
    v[1] = '{"w_r0_ignored", 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    v[2] = '{"w_r2",         1'b1, 5'd2,  32'b1100,     5'd1,  5'd2,  32'h666,      32'b1100};
    v[3] = '{"w_r3_alu_ops", 1'b1, 5'd3,  32'b1010,     5'd2,  5'd3,  32'b1100,     32'b1010};
    v[4] = '{"we0_hold_r2",  1'b0, 5'd2,  32'h1234,     5'd2,  5'd3,  32'b1100,     32'b1010};
    v[5] = '{"w_r31_same",   1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF};
    v[6] = '{"overwrite_r3", 1'b1, 5'd3,  32'h5555,     5'd3,  5'd1,  32'h5555,     32'h666};
    v[7] = '{"we0_readback", 1'b0, 5'd31, 32'h0,        5'd31, 5'd2,  32'hDEADBEEF, 32'b1100};

    Rna = 1; Rnb = 31;
    #12;
    chk("reset_qa", Qa, 32'h0);
    chk("reset_qb", Qb, 32'h0);
    Clr = 0;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      We = v[i].we; Wn = v[i].wn; D = v[i].d; Rna = v[i].rna; Rnb = v[i].rnb;
      @(posedge Clk); #1;
      chk({v[i].nm, "_qa"}, Qa, v[i].qa);
      chk({v[i].nm, "_qb"}, Qb, v[i].qb);
    end

    @(negedge Clk);
    We = 1; Wn = 4; D = 32'h777; Rna = 4; Rnb = 1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("pre_edge_qa", Qa, 32'h777);
`else
    chk("pre_edge_qa", Qa, 32'h0);
`endif
    chk("pre_edge_qb", Qb, 32'h666);
    @(posedge Clk); #1;
    chk("post_edge_qa", Qa, 32'h777);

    @(negedge Clk);
    We = 1; Wn = 5; D = 32'hAA; Rna = 5; Rnb = 31;
    #2;
    Clr = 1;
    #1;
    chk("clr_async_qa", Qa, 32'h0);
    chk("clr_async_qb", Qb, 32'h0);
    @(posedge Clk); #1;
    chk("clr_edge_qa", Qa, 32'h0);
    @(negedge Clk);
    We = 0;
    Clr = 0;
    #1;
    chk("clr_r5_discard", Qa, 32'h0);
    chk("clr_r31_cleared", Qb, 32'h0);
    Rna = 1; Rnb = 3;
    #1;
    chk("clr_r1_cleared", Qa, 32'h0);
    chk("clr_r3_cleared", Qb, 32'h0);

    We = 1; Wn = 6; D = 32'hBB; Rna = 6; Rnb = 5;
    @(posedge Clk); #1;
    chk("first_edge_write", Qa, 32'hBB);
    chk("r5_still_zero", Qb, 32'h0);
    We = 0;
    @(posedge Clk); #1;
    chk("r6_held", Qa, 32'hBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter DW, default 32, data width of each register and of every data port.
REQ-002 The block SHALL have parameter AW, default 5, register-number width; register count is 2**AW (32 at default).
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Clr, input, 1, asynchronous active-high reset clearing every register.
REQ-005 The block SHALL have port Rna, input, AW, read-port A register number.
REQ-006 The block SHALL have port Rnb, input, AW, read-port B register number.
REQ-007 The block SHALL have port Wn, input, AW, write-port register number.
REQ-008 The block SHALL have port D, input, DW, write data.
REQ-009 The block SHALL have port We, input, 1, write enable, active-high.
REQ-010 The block SHALL have port Qa, output, DW, read-port A data, wired to the ALU X operand.
REQ-011 The block SHALL have port Qb, output, DW, read-port B data, wired to the ALU Y operand.
REQ-012 The block SHALL use one clock (Clk) with asynchronous, active-high reset (Clr), as already decided.

Function
REQ-013 The block SHALL hold 2**AW registers r0..r(2**AW-1), each DW bits.
REQ-014 The block SHALL write D into r[Wn] on a rising Clk edge when We=1, Clr=0 and Wn!=0; no other register changes.
REQ-015 The block SHALL ignore writes to r0; r0 SHALL always read 0, with We=1 and Wn=0 a no-op.
REQ-016 The block SHALL hold all registers unchanged on any edge where We=0.
REQ-017 The block SHALL make Qa=r[Rna] and Qb=r[Rnb] combinationally, zero-cycle latency from address change.
REQ-018 The block SHALL make a completed write visible on Qa/Qb in the same cycle as the edge that performs it, once the edge has passed.
REQ-019 The block SHALL support Rna=Rnb; both ports then return identical data.
REQ-020 The block SHALL treat addresses as unsigned, with all 2**AW values legal; no wrap or out-of-range case exists.
REQ-021 The block SHALL let Clr override any simultaneous write.

Reset
REQ-022 The block SHALL force all registers to 0 immediately on assertion of Clr, independent of Clk.
REQ-023 The block SHALL drive Qa=Qb=0 while Clr=1, for any Rna/Rnb.
REQ-024 The block SHALL discard a write whose edge coincides with Clr=1; it SHALL NOT be replayed after release.
REQ-025 The block SHALL accept writes from the first rising Clk edge after Clr deasserts.

Configuration
REQ-026 The block SHALL compile write-to-read bypass in when macro REGFILE_BYPASS_EN is defined.
REQ-027 With REGFILE_BYPASS_EN defined, the block SHALL drive Qa=D when We=1, Wn=Rna and Rna!=0, and likewise Qb=D when Wn=Rnb and Rnb!=0, combinationally before the edge; Clr=1 still forces 0.
REQ-028 With REGFILE_BYPASS_EN undefined, the block SHALL return pre-edge stored contents until the write edge, with no combinational path from D or We to Qa/Qb.

Verification
REQ-029 The bench SHALL pulse Clr=1, then set Rna=1 and Rnb=31, and require Qa=Qb=32'h0.
REQ-030 The bench SHALL write We=1, Wn=1, D=32'h666, clock once, read Rna=1, and require Qa=32'h666; same-cycle Qa=32'h666 SHALL also hold with REGFILE_BYPASS_EN defined, and Qa=32'h0 before the edge without it.
REQ-031 The bench SHALL write We=1, Wn=0, D=32'hFFFFFFFF, clock once, set Rna=0, and require Qa=32'h0.
REQ-032 The bench SHALL write r2=32'b1100 and r3=32'b1010, set Rna=2 and Rnb=3, and require Qa=32'b1100 and Qb=32'b1010, feeding ALU Aluc=2'b10.
REQ-033 The bench SHALL set We=0, Wn=2, D=32'h1234, clock once, and require r2 to still read 32'b1100.
REQ-034 The bench SHALL assert Clr mid-cycle with We=1, Wn=5, D=32'hAA, then after release read Rna=5 and require Qa=32'h0.
